log2_multi_pipe: RTL and testbench

- Multi-channel, tagged Log2 engine implementing the G.729 Log2 and Log2_norm basic operations, bit-exact to the ITU reference C.
- Successor to the single-mode Log2 block. Adds:
  - selectable normalisation speed (bits shifted per cycle),
  - a Log2_norm mode for inputs the caller has already normalised,
  - a channel tag that travels with each request,
  - explicit busy and error reporting.
- Shared by the LSP/gain-quantiser paths: one instance is time-multiplexed among callers.

---
 rtl/log2_multi_pipe_pkg.sv | 53 +++++
 rtl/log2_multi_pipe_rom.sv | 25 ++
 rtl/log2_multi_pipe.sv | 139 +++++++++++++
 tb/tb_log2_multi_pipe.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/log2_multi_pipe_pkg.sv
// Purpose: shared types, constants and saturating arithmetic helpers for the Log2 engine.
// Latency: n/a (package).
// Backpressure: n/a (package).
package log2_multi_pipe_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_NORM   = 3'd1,
    ST_LOOKUP = 3'd2,
    ST_INTERP = 3'd3,
    ST_DONE   = 3'd4
  } state_t;

  localparam logic signed [31:0] MAX_32 = 32'sh7FFF_FFFF;
  localparam logic signed [31:0] MIN_32 = 32'sh8000_0000;

  // log2(1 + k/32) in Q15, k = 0..32
  localparam logic [15:0] LOG2_TABLE [33] = '{
    16'd0,     16'd1455,  16'd2866,  16'd4236,  16'd5568,  16'd6863,  16'd8124,
    16'd9352,  16'd10549, 16'd11716, 16'd12855, 16'd13967, 16'd15054, 16'd16117,
    16'd17156, 16'd18172, 16'd19167, 16'd20142, 16'd21097, 16'd22033, 16'd22951,
    16'd23852, 16'd24735, 16'd25603, 16'd26455, 16'd27291, 16'd28113, 16'd28922,
    16'd29716, 16'd30497, 16'd31266, 16'd32023, 16'd32767
  };

  // 16x16 fractional multiply: (a*b)<<1, saturating the single -1*-1 overflow case.
  function automatic logic [31:0] l_mult(input logic signed [15:0] a,
                                         input logic signed [15:0] b);
    logic signed [31:0] p;
    p = a * b;
    if (a == 16'sh8000 && b == 16'sh8000) return MAX_32;
    return p <<< 1;
  endfunction

  // 32-bit subtract saturating to MIN_32/MAX_32.
  function automatic logic [31:0] l_sub_sat(input logic signed [31:0] a,
                                            input logic signed [31:0] b);
    logic signed [32:0] d;
    d = {a[31], a} - {b[31], b};
    if (d[32] != d[31]) return d[32] ? MIN_32 : MAX_32;
    return d[31:0];
  endfunction

  // 16-bit subtract saturating to 0x8000/0x7FFF.
  function automatic logic [15:0] sub16_sat(input logic signed [15:0] a,
                                            input logic signed [15:0] b);
    logic signed [16:0] d;
    d = {a[15], a} - {b[15], b};
    if (d[16] != d[15]) return d[16] ? 16'h8000 : 16'h7FFF;
    return d[15:0];
  endfunction

endpackage

// File: rtl/log2_multi_pipe_rom.sv
// Purpose: dual-read log2 table, returns entries idx and idx+1 together.
// Latency: 1 cycle (registered outputs).
// Backpressure: none; reads every cycle.
module log2_table_rom
  import log2_multi_pipe_pkg::*;
(
  input  logic        clock,
  input  logic [4:0]  idx,
  output logic [15:0] rd_lo,
  output logic [15:0] rd_hi
);

  logic [5:0] idx_lo;
  logic [5:0] idx_hi;

  assign idx_lo = {1'b0, idx};
  assign idx_hi = idx_lo + 6'd1;

  // Registered read of the two interpolation end points.
  always_ff @(posedge clock) begin
    rd_lo <= LOG2_TABLE[idx_lo];
    rd_hi <= LOG2_TABLE[idx_hi];
  end

endmodule

// File: rtl/log2_multi_pipe.sv
// Purpose: tagged G.729 Log2 / Log2_norm engine, time-shared among callers.
// Latency: max(1, ceil(n/NORM_STEP)) + 3 edges for positive operands, 1 edge for operands <= 0.
// Backpressure: start ignored while busy; no queueing, result held until next accepted start.
module log2_multi_pipe
  import log2_multi_pipe_pkg::*;
#(
  parameter int NORM_STEP = 4,
  parameter int TAG_WIDTH = 3
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 start,
  input  logic                 mode,
  input  logic [31:0]          in,
  input  logic [15:0]          exp_in,
  input  logic [TAG_WIDTH-1:0] tag_in,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          exponent,
  output logic [15:0]          fraction,
  output logic [TAG_WIDTH-1:0] tag_out,
  output logic                 err
);

  state_t               state;
  logic [31:0]          x;
  logic [15:0]          n;
  logic                 mode_q;
  logic [TAG_WIDTH-1:0] tag_q;
  logic                 interp_ph;
  logic [31:0]          prod;

  logic [3:0]           sh;
  logic [31:0]          x_shift;
  logic                 x_nonpos;
  logic [15:0]          tab_lo;
  logic [15:0]          tab_hi;
  logic [15:0]          tmp;
  logic [31:0]          l_y;

  // Per-cycle shift: leading redundant sign bits below bit 31, capped at NORM_STEP.
  always_comb begin
    logic stop;
    sh   = '0;
    stop = 1'b0;
    for (int j = 0; j < NORM_STEP; j++) begin
      if (!stop && !x[30-j]) sh = sh + 4'd1;
      else                   stop = 1'b1;
    end
  end

  assign x_shift  = x << sh;
  assign x_nonpos = x[31] || (x == 32'd0);

  // Once normalised, x[30] is 1 so x[29:25] is the table index i = x[30:25] - 32.
  log2_table_rom u_rom (
    .clock (clock),
    .idx   (x[29:25]),
    .rd_lo (tab_lo),
    .rd_hi (tab_hi)
  );

  assign tmp = tab_lo - tab_hi;
  assign l_y = l_sub_sat({tab_lo, 16'h0000}, prod);

  // Request FSM: accept, normalise, table read, two-step interpolation, hold result.
  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= ST_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      exponent  <= '0;
      fraction  <= '0;
      tag_out   <= '0;
      x         <= '0;
      n         <= '0;
      mode_q    <= 1'b0;
      tag_q     <= '0;
      interp_ph <= 1'b0;
      prod      <= '0;
    end else begin
      case (state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            state     <= ST_NORM;
            busy      <= 1'b1;
            done      <= 1'b0;
            err       <= 1'b0;
            x         <= in;
            n         <= mode ? exp_in : 16'd0;
            mode_q    <= mode;
            tag_q     <= tag_in;
            interp_ph <= 1'b0;
          end
        end
        ST_NORM: begin
          if (x_nonpos) begin
            // Non-positive operand: flag it and report a zero result at once.
            state    <= ST_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            err      <= 1'b1;
            exponent <= '0;
            fraction <= '0;
            tag_out  <= tag_q;
          end else if (mode_q) begin
            state <= ST_LOOKUP;
          end else begin
            x <= x_shift;
            n <= n + {12'd0, sh};
            if (x_shift[30]) state <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          state     <= ST_INTERP;
          interp_ph <= 1'b0;
        end
        ST_INTERP: begin
          if (!interp_ph) begin
            // Product registered first to split the multiply from the saturating subtract.
            prod      <= l_mult(tmp, {1'b0, x[24:10]});
            interp_ph <= 1'b1;
          end else begin
            state    <= ST_DONE;
            busy     <= 1'b0;
            done     <= 1'b1;
            err      <= 1'b0;
            fraction <= l_y[31:16];
            exponent <= sub16_sat(16'sd30, n);
            tag_out  <= tag_q;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_log2_multi_pipe.sv
// Bench for log2_multi_pipe: vector table, corner-case sequences and random replay
// against a behavioural model, all results flowing through a scoreboard queue.
module tb_log2_multi_pipe;

  localparam int TW = 3;
  localparam int NS = 4;

  localparam int TAB [33] = '{
    0, 1455, 2866, 4236, 5568, 6863, 8124, 9352, 10549, 11716, 12855, 13967, 15054,
    16117, 17156, 18172, 19167, 20142, 21097, 22033, 22951, 23852, 24735, 25603,
    26455, 27291, 28113, 28922, 29716, 30497, 31266, 32023, 32767
  };

  logic          clock = 1'b0;
  logic          reset, start, mode;
  logic [31:0]   in_v;
  logic [15:0]   exp_in;
  logic [TW-1:0] tag_in;

  logic busy4, done4, err4, busy1, done1, err1, busy8, done8, err8;
  logic [15:0] ex4, fr4, ex1, fr1, ex8, fr8;
  logic [TW-1:0] tag4, tag1, tag8;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  log2_multi_pipe #(.NORM_STEP(4), .TAG_WIDTH(TW)) u4 (
    .clock(clock), .reset(reset), .start(start), .mode(mode), .in(in_v), .exp_in(exp_in),
    .tag_in(tag_in), .busy(busy4), .done(done4), .exponent(ex4), .fraction(fr4),
    .tag_out(tag4), .err(err4));

  log2_multi_pipe #(.NORM_STEP(1), .TAG_WIDTH(TW)) u1 (
    .clock(clock), .reset(reset), .start(start), .mode(mode), .in(in_v), .exp_in(exp_in),
    .tag_in(tag_in), .busy(busy1), .done(done1), .exponent(ex1), .fraction(fr1),
    .tag_out(tag1), .err(err1));

  log2_multi_pipe #(.NORM_STEP(8), .TAG_WIDTH(TW)) u8 (
    .clock(clock), .reset(reset), .start(start), .mode(mode), .in(in_v), .exp_in(exp_in),
    .tag_in(tag_in), .busy(busy8), .done(done8), .exponent(ex8), .fraction(fr8),
    .tag_out(tag8), .err(err8));

  typedef struct {
    logic [15:0]   ex;
    logic [15:0]   fr;
    logic          er;
    logic [TW-1:0] tag;
    int            acc;
    int            lat;
  } exp_t;

  typedef struct {
    logic          md;
    logic [31:0]   x;
    logic [15:0]   e;
    logic [TW-1:0] tag;
    logic [15:0]   ex;
    logic [15:0]   fr;
    logic          er;
    int            lat;
  } vec_t;

  exp_t sb[$];
  vec_t vecs[11];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h required %0h", nm, act, req);
    end
  endtask

  // Behavioural G.729 Log2 / Log2_norm with latency expectation for NORM_STEP = NS.
  function automatic void model(input logic md, input logic [31:0] xi, input logic [15:0] e,
                                output logic [15:0] ex, output logic [15:0] fr,
                                output logic er, output int lat);
    logic [31:0] x;
    int n, i, a, tmp, expo;
    longint ly;
    x = xi;
    if (x[31] || x == 32'd0) begin
      ex = 16'd0; fr = 16'd0; er = 1'b1; lat = 1;
      return;
    end
    er = 1'b0;
    if (!md) begin
      n = 0;
      while (!x[30]) begin x = x << 1; n++; end
      lat = (n + NS - 1) / NS;
      if (lat < 1) lat = 1;
      lat += 3;
    end else begin
      n = int'($signed(e));
      lat = 4;
    end
    expo = 30 - n;
    if (expo > 32767)  expo = 32767;
    if (expo < -32768) expo = -32768;
    ex  = expo[15:0];
    i   = int'(x[30:25]) - 32;
    a   = int'(x[24:10]);
    tmp = TAB[i] - TAB[i+1];
    ly  = longint'(TAB[i]) * 65536 - longint'(tmp) * a * 2;
    if (ly > 64'sd2147483647)  ly = 64'sd2147483647;
    if (ly < -64'sd2147483648) ly = -64'sd2147483648;
    fr = ly[31:16];
  endfunction

  // Drive one start pulse from a negedge; optionally record the expected result.
  task automatic issue(input logic md, input logic [31:0] x, input logic [15:0] e,
                       input logic [TW-1:0] t, input bit push, input logic [15:0] ex,
                       input logic [15:0] fr, input logic er, input int lat);
    exp_t r;
    mode = md; in_v = x; exp_in = e; tag_in = t; start = 1'b1;
    if (push) begin
      r.ex = ex; r.fr = fr; r.er = er; r.tag = t; r.acc = cyc + 1; r.lat = lat;
      sb.push_back(r);
    end
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_drain(input int limit);
    int k;
    k = 0;
    while (sb.size() != 0 && k < limit) begin
      @(negedge clock);
      k++;
    end
    if (sb.size() != 0) begin
      n_tests++; n_fail++;
      $display("FAIL drain_timeout: got %0d outstanding required 0", sb.size());
      sb.delete();
    end
  endtask

  // Scoreboard monitor: each rising done on the NORM_STEP=4 instance retires one entry.
  logic prev4 = 1'b0;
  always @(negedge clock) begin
    exp_t e;
    if (reset) begin
      prev4 = 1'b0;
    end else begin
      if (done4 && !prev4) begin
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_done: got tag %0h required no result", tag4);
        end else begin
          e = sb.pop_front();
          check("exponent", ex4, e.ex);
          check("fraction", fr4, e.fr);
          check("err", err4, e.er);
          check("tag_out", tag4, e.tag);
          check("latency", cyc - e.acc, e.lat);
        end
      end
      prev4 = done4;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int k, a_cyc, lat1, lat8, q_lat;
    logic md;
    logic [31:0] x;
    logic [15:0] e, ex, fr;
    logic er;
    logic [TW-1:0] t;

    vecs[0]  = '{1'b0, 32'h4000_0000, 16'h0000, 3'd1, 16'h001E, 16'h0000, 1'b0, 4};
    vecs[1]  = '{1'b0, 32'h0000_0001, 16'h0000, 3'd2, 16'h0000, 16'h0000, 1'b0, 11};
    vecs[2]  = '{1'b0, 32'h7FFF_FFFF, 16'h0000, 3'd3, 16'h001E, 16'h7FFE, 1'b0, 4};
    vecs[3]  = '{1'b0, 32'h6000_0000, 16'h0000, 3'd4, 16'h001E, 16'h4ADF, 1'b0, 4};
    vecs[4]  = '{1'b0, 32'h0000_0000, 16'h0000, 3'd5, 16'h0000, 16'h0000, 1'b1, 1};
    vecs[5]  = '{1'b0, 32'h8000_0000, 16'h0000, 3'd6, 16'h0000, 16'h0000, 1'b1, 1};
    vecs[6]  = '{1'b1, 32'h6000_0000, 16'h0004, 3'd7, 16'h001A, 16'h4ADF, 1'b0, 4};
    vecs[7]  = '{1'b1, 32'hFFFF_FFFF, 16'h0003, 3'd0, 16'h0000, 16'h0000, 1'b1, 1};
    vecs[8]  = '{1'b0, 32'h0001_0000, 16'h0000, 3'd1, 16'h0010, 16'h0000, 1'b0, 7};
    vecs[9]  = '{1'b1, 32'h4000_0000, 16'h8000, 3'd2, 16'h7FFF, 16'h0000, 1'b0, 4};
    vecs[10] = '{1'b0, 32'h0000_0003, 16'h0000, 3'd3, 16'h0001, 16'h4ADF, 1'b0, 11};

    reset = 1'b1; start = 1'b0; mode = 1'b0; in_v = '0; exp_in = '0; tag_in = '0;
    repeat (3) @(negedge clock);
    check("rst_busy", busy4, 0);
    check("rst_done", done4, 0);
    check("rst_err", err4, 0);
    check("rst_exponent", ex4, 0);
    check("rst_fraction", fr4, 0);
    check("rst_tag", tag4, 0);
    reset = 1'b0;
    @(negedge clock);

    // Vector table
    for (int v = 0; v < 11; v++) begin
      issue(vecs[v].md, vecs[v].x, vecs[v].e, vecs[v].tag, 1'b1,
            vecs[v].ex, vecs[v].fr, vecs[v].er, vecs[v].lat);
      wait_drain(100);
    end

    // Start while busy is ignored; original tag is reported.
    issue(1'b0, 32'h0000_0001, 16'h0, 3'd5, 1'b1, 16'h0000, 16'h0000, 1'b0, 11);
    repeat (2) @(negedge clock);
    check("busy_mid_norm", busy4, 1);
    issue(1'b0, 32'h4000_0000, 16'h0, 3'd2, 1'b0, 16'h0, 16'h0, 1'b0, 0);
    wait_drain(100);
    repeat (3) @(negedge clock);
    check("tag_hold", tag4, 5);

    // Back-to-back: new start in the first DONE cycle.
    issue(1'b0, 32'h7FFF_FFFF, 16'h0, 3'd3, 1'b1, 16'h001E, 16'h7FFE, 1'b0, 4);
    k = 0;
    while (!done4 && k < 50) begin @(negedge clock); k++; end
    check("b2b_first_done", done4, 1);
    issue(1'b0, 32'h6000_0000, 16'h0, 3'd4, 1'b1, 16'h001E, 16'h4ADF, 1'b0, 4);
    check("b2b_done_drop", done4, 0);
    wait_drain(50);

    // Reset mid-NORM, asserted together with start: aborts with no result.
    issue(1'b0, 32'h0000_0001, 16'h0, 3'd6, 1'b0, 16'h0, 16'h0, 1'b0, 0);
    repeat (2) @(negedge clock);
    reset = 1'b1; start = 1'b1; in_v = 32'h4000_0000;
    @(negedge clock);
    check("abort_busy", busy4, 0);
    check("abort_done", done4, 0);
    check("abort_err", err4, 0);
    check("abort_exponent", ex4, 0);
    check("abort_fraction", fr4, 0);
    check("abort_tag", tag4, 0);
    reset = 1'b0; start = 1'b0;
    @(negedge clock);
    issue(1'b0, 32'h4000_0000, 16'h0, 3'd6, 1'b1, 16'h001E, 16'h0000, 1'b0, 4);
    wait_drain(50);

    // Normalisation speed: NORM_STEP 1 and 8 on in = 1.
    k = 0;
    while ((busy1 || busy8) && k < 60) begin @(negedge clock); k++; end
    a_cyc = cyc + 1;
    issue(1'b0, 32'h0000_0001, 16'h0, 3'd7, 1'b1, 16'h0000, 16'h0000, 1'b0, 11);
    lat1 = -1; lat8 = -1;
    for (int w = 0; w < 45; w++) begin
      if (done8 && lat8 < 0) lat8 = cyc - a_cyc;
      if (done1 && lat1 < 0) lat1 = cyc - a_cyc;
      if (lat1 >= 0 && lat8 >= 0) break;
      @(negedge clock);
    end
    check("lat_step1", lat1, 33);
    check("lat_step8", lat8, 7);
    check("step1_exponent", ex1, 0);
    check("step8_tag", tag8, 7);
    wait_drain(50);

    // Random replay against the model.
    for (int r = 0; r < 150; r++) begin
      md = ($urandom_range(0, 3) == 0);
      e  = '0;
      if (md) begin
        x = ($urandom & 32'h3FFF_FFFF) | 32'h4000_0000;
        e = 16'($urandom_range(0, 40));
      end else begin
        x = $urandom >> $urandom_range(0, 31);
        if ($urandom_range(0, 7) == 0) x = $urandom;
      end
      t = TW'($urandom_range(0, 7));
      model(md, x, e, ex, fr, er, q_lat);
      issue(md, x, e, t, 1'b1, ex, fr, er, q_lat);
      wait_drain(100);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
